// File: rtl/ysyx_23060278_idu_stage_if.sv
// IDU stage bus: IFU-side handshake, flush, EXU-side handshake and control bundle.
// master = driver of the instruction side (IFU/EXU environment), slave = the IDU stage.
interface ysyx_23060278_idu_stage_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_inst;
    logic [XLEN-1:0]   in_pc;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_pc;
    logic [XLEN-1:0]   out_imm;
    logic [REG_AW-1:0] out_rs1;
    logic [REG_AW-1:0] out_rs2;
    logic [REG_AW-1:0] out_rd;
    logic [3:0]        out_aluop;
    logic              out_alusrc_a;
    logic              out_alusrc_b;
    logic              out_regwrite;
    logic [1:0]        out_wbsel;
    logic              out_memread;
    logic              out_memwrite;
    logic [2:0]        out_memsize;
    logic              out_branch;
    logic [2:0]        out_brfunc;
    logic              out_jal;
    logic              out_jalr;
    logic              out_ebreak;
    logic              out_illegal;

    modport master (
        output in_valid, in_inst, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_imm,
        input  out_rs1, out_rs2, out_rd, out_aluop,
        input  out_alusrc_a, out_alusrc_b, out_regwrite, out_wbsel,
        input  out_memread, out_memwrite, out_memsize,
        input  out_branch, out_brfunc, out_jal, out_jalr,
        input  out_ebreak, out_illegal
    );

    modport slave (
        input  in_valid, in_inst, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc, out_imm,
        output out_rs1, out_rs2, out_rd, out_aluop,
        output out_alusrc_a, out_alusrc_b, out_regwrite, out_wbsel,
        output out_memread, out_memwrite, out_memsize,
        output out_branch, out_brfunc, out_jal, out_jalr,
        output out_ebreak, out_illegal
    );
endinterface

// File: rtl/ysyx_23060278_idu_stage.sv
// Registered RV32I/E decode stage between IFU and EXU with valid/ready on both sides.
// Ports: clk, rst (async high), bus (slave modport), perf_decoded (saturating count).
module ysyx_23060278_idu_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    ysyx_23060278_idu_stage_if.slave  bus,
    output logic [CNT_W-1:0]          perf_decoded
);
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_SYS   = 7'b1110011;
    localparam logic [6:0] F7_ALT   = 7'b0100000;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [3:0]        aluop;
        logic              alusrc_a;
        logic              alusrc_b;
        logic              regwrite;
        logic [1:0]        wbsel;
        logic              memread;
        logic              memwrite;
        logic [2:0]        memsize;
        logic              branch;
        logic [2:0]        brfunc;
        logic              jal;
        logic              jalr;
        logic              ebreak;
        logic              illegal;
    } bundle_t;

    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? 4'd1 : 4'd0;
            3'b001:  op = 4'd2;
            3'b010:  op = 4'd3;
            3'b011:  op = 4'd4;
            3'b100:  op = 4'd5;
            3'b101:  op = alt ? 4'd7 : 4'd6;
            3'b110:  op = 4'd8;
            default: op = 4'd9;
        endcase
        return op;
    endfunction

    // True when the index cannot be addressed with REG_AW bits (RV32E).
    function automatic logic reg_over(input logic [4:0] idx);
        return (idx >> REG_AW) != 5'd0;
    endfunction

    logic [31:0] inst;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign inst  = bus.in_inst;
    assign opc   = inst[6:0];
    assign f3    = inst[14:12];
    assign f7    = inst[31:25];
    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'd0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    bundle_t     dec;
    bundle_t     q;
    logic        valid_q;
    logic        accept;
    logic [31:0] imm32;
    logic        use_rs1, use_rs2, use_rd, wclass, bad;

    always_comb begin
        dec     = '0;
        imm32   = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        wclass  = 1'b0;
        bad     = 1'b0;
        dec.pc  = bus.in_pc;
        dec.rs1 = inst[15 +: REG_AW];
        dec.rs2 = inst[20 +: REG_AW];
        dec.rd  = inst[7 +: REG_AW];
        unique case (opc)
            OP_LUI: begin
                imm32     = imm_u;
                dec.wbsel = 2'b10;
                use_rd    = 1'b1;
                wclass    = 1'b1;
            end
            OP_AUIPC: begin
                imm32        = imm_u;
                dec.alusrc_a = 1'b1;
                dec.alusrc_b = 1'b1;
                use_rd       = 1'b1;
                wclass       = 1'b1;
            end
            OP_JAL: begin
                imm32        = imm_j;
                dec.alusrc_a = 1'b1;
                dec.alusrc_b = 1'b1;
                dec.wbsel    = 2'b01;
                dec.jal      = 1'b1;
                use_rd       = 1'b1;
                wclass       = 1'b1;
            end
            OP_JALR: begin
                imm32        = imm_i;
                dec.alusrc_b = 1'b1;
                dec.wbsel    = 2'b01;
                dec.jalr     = 1'b1;
                use_rs1      = 1'b1;
                use_rd       = 1'b1;
                wclass       = 1'b1;
                bad          = f3 != 3'b000;
            end
            OP_BR: begin
                imm32      = imm_b;
                dec.branch = 1'b1;
                dec.brfunc = f3;
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
                bad        = f3[2:1] == 2'b01;
            end
            OP_LD: begin
                imm32        = imm_i;
                dec.alusrc_b = 1'b1;
                dec.memread  = 1'b1;
                dec.memsize  = f3;
                dec.wbsel    = 2'b11;
                use_rs1      = 1'b1;
                use_rd       = 1'b1;
                wclass       = 1'b1;
                bad          = (f3 == 3'b011) || (f3[2:1] == 2'b11);
            end
            OP_ST: begin
                imm32        = imm_s;
                dec.alusrc_b = 1'b1;
                dec.memwrite = 1'b1;
                dec.memsize  = f3;
                use_rs1      = 1'b1;
                use_rs2      = 1'b1;
                bad          = f3 > 3'b010;
            end
            OP_IMM: begin
                imm32        = imm_i;
                dec.alusrc_b = 1'b1;
                dec.aluop    = alu_op(f3, (f3 == 3'b101) && (f7 == F7_ALT));
                use_rs1      = 1'b1;
                use_rd       = 1'b1;
                wclass       = 1'b1;
                // Shift-immediates reuse f7 as an encoding field.
                if (f3 == 3'b001)
                    bad = f7 != 7'd0;
                else if (f3 == 3'b101)
                    bad = (f7 != 7'd0) && (f7 != F7_ALT);
            end
            OP_REG: begin
                dec.aluop = alu_op(f3, f7 == F7_ALT);
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                use_rd    = 1'b1;
                wclass    = 1'b1;
                bad       = !((f7 == 7'd0) ||
                              ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101))));
            end
            OP_SYS: begin
                if (inst == 32'h0010_0073)
                    dec.ebreak = 1'b1;
                else
                    bad = 1'b1;
            end
            default: bad = 1'b1;
        endcase
        if ((use_rs1 && reg_over(inst[19:15])) ||
            (use_rs2 && reg_over(inst[24:20])) ||
            (use_rd  && reg_over(inst[11:7])))
            bad = 1'b1;
        dec.imm      = {XLEN{imm32[31]}};
        dec.imm[31:0] = imm32;
        dec.regwrite = wclass && (inst[11:7] != 5'd0) && !bad;
        dec.illegal  = bad;
        if (bad) begin
            dec.memread  = 1'b0;
            dec.memwrite = 1'b0;
            dec.branch   = 1'b0;
            dec.jal      = 1'b0;
            dec.jalr     = 1'b0;
            dec.ebreak   = 1'b0;
        end
    end

    assign bus.in_ready = !valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready && !bus.flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            q       <= '0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            q       <= dec;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            perf_decoded <= '0;
        else if (valid_q && bus.out_ready && !(&perf_decoded))
            perf_decoded <= perf_decoded + 1'b1;
    end

    assign bus.out_valid    = valid_q;
    assign bus.out_pc       = q.pc;
    assign bus.out_imm      = q.imm;
    assign bus.out_rs1      = q.rs1;
    assign bus.out_rs2      = q.rs2;
    assign bus.out_rd       = q.rd;
    assign bus.out_aluop    = q.aluop;
    assign bus.out_alusrc_a = q.alusrc_a;
    assign bus.out_alusrc_b = q.alusrc_b;
    assign bus.out_regwrite = q.regwrite;
    assign bus.out_wbsel    = q.wbsel;
    assign bus.out_memread  = q.memread;
    assign bus.out_memwrite = q.memwrite;
    assign bus.out_memsize  = q.memsize;
    assign bus.out_branch   = q.branch;
    assign bus.out_brfunc   = q.brfunc;
    assign bus.out_jal      = q.jal;
    assign bus.out_jalr     = q.jalr;
    assign bus.out_ebreak   = q.ebreak;
    assign bus.out_illegal  = q.illegal;
endmodule

// File: tb/tb_ysyx_23060278_idu_stage.sv
// Directed bench for the IDU stage: an RV32I instance and an RV32E instance with a
// 4-bit counter share the same stimulus; expected values are hand-computed.
module tb_ysyx_23060278_idu_stage;
    logic        clk;
    logic        rst;
    logic [31:0] perf_a;
    logic [3:0]  perf_b;
    int          n_cmp;
    int          n_err;

    ysyx_23060278_idu_stage_if #(.XLEN(32), .REG_AW(5)) a ();
    ysyx_23060278_idu_stage_if #(.XLEN(32), .REG_AW(4)) b ();

    ysyx_23060278_idu_stage #(.XLEN(32), .REG_AW(5), .CNT_W(32)) u_a (
        .clk          (clk),
        .rst          (rst),
        .bus          (a.slave),
        .perf_decoded (perf_a)
    );

    ysyx_23060278_idu_stage #(.XLEN(32), .REG_AW(4), .CNT_W(4)) u_b (
        .clk          (clk),
        .rst          (rst),
        .bus          (b.slave),
        .perf_decoded (perf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p);
        a.in_valid = v;
        b.in_valid = v;
        a.in_inst  = i;
        b.in_inst  = i;
        a.in_pc    = p;
        b.in_pc    = p;
    endtask

    task automatic set_rdy(input logic r);
        a.out_ready = r;
        b.out_ready = r;
    endtask

    task automatic set_flush(input logic f);
        a.flush = f;
        b.flush = f;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
        set_rdy(1'b1);
        set_flush(1'b0);
        #2;
        check("rst_valid", a.out_valid, 0);
        check("rst_imm", a.out_imm, 0);
        check("rst_aluop", a.out_aluop, 0);
        check("rst_perf", perf_a, 0);
        check("rst_in_ready", a.in_ready, 1);
        @(negedge clk);
        rst = 1'b0;

        // addi x1,x0,5 then sub x3,x1,x2 back-to-back
        drive(1'b1, 32'h0050_0093, 32'h8000_0000);
        @(negedge clk);
        check("addi_valid", a.out_valid, 1);
        check("addi_imm", a.out_imm, 5);
        check("addi_rd", a.out_rd, 1);
        check("addi_aluop", a.out_aluop, 0);
        check("addi_srcb", a.out_alusrc_b, 1);
        check("addi_rw", a.out_regwrite, 1);
        check("addi_wbsel", a.out_wbsel, 0);
        check("addi_pc", a.out_pc, 32'h8000_0000);
        check("addi_perf", perf_a, 0);
        drive(1'b1, 32'h4020_81B3, 32'h8000_0004);
        @(negedge clk);
        check("sub_valid", a.out_valid, 1);
        check("sub_aluop", a.out_aluop, 1);
        check("sub_rs1", a.out_rs1, 1);
        check("sub_rs2", a.out_rs2, 2);
        check("sub_rd", a.out_rd, 3);
        check("sub_pc", a.out_pc, 32'h8000_0004);
        check("sub_perf", perf_a, 1);

        // lui x5,0x12345 under 3 cycles of backpressure, then sw on the drain cycle
        drive(1'b1, 32'h1234_52B7, 32'h8000_0008);
        @(negedge clk);
        set_rdy(1'b0);
        drive(1'b1, 32'h0020_A423, 32'h8000_000C);
        #1;
        check("bp_in_ready", a.in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_valid", a.out_valid, 1);
            check("bp_imm", a.out_imm, 32'h1234_5000);
            check("bp_wbsel", a.out_wbsel, 2);
            check("bp_rd", a.out_rd, 5);
            check("bp_pc", a.out_pc, 32'h8000_0008);
        end
        check("bp_perf", perf_a, 2);
        set_rdy(1'b1);
        #1;
        check("drain_in_ready", a.in_ready, 1);
        @(negedge clk);
        check("sw_valid", a.out_valid, 1);
        check("sw_memwrite", a.out_memwrite, 1);
        check("sw_memsize", a.out_memsize, 2);
        check("sw_imm", a.out_imm, 8);
        check("sw_rw", a.out_regwrite, 0);
        check("sw_rs1", a.out_rs1, 1);
        check("sw_perf", perf_a, 3);

        // beq x0,x0,-4
        drive(1'b1, 32'hFE00_0EE3, 32'h8000_0010);
        @(negedge clk);
        check("beq_branch", a.out_branch, 1);
        check("beq_brfunc", a.out_brfunc, 0);
        check("beq_imm", a.out_imm, 32'hFFFF_FFFC);
        check("beq_rw", a.out_regwrite, 0);
        check("beq_perf", perf_a, 4);

        // jal x1,8 and lw x5,4(x2)
        drive(1'b1, 32'h0080_00EF, 32'h8000_0014);
        @(negedge clk);
        check("jal_flag", a.out_jal, 1);
        check("jal_imm", a.out_imm, 8);
        check("jal_wbsel", a.out_wbsel, 1);
        check("jal_srca", a.out_alusrc_a, 1);
        check("jal_rw", a.out_regwrite, 1);
        drive(1'b1, 32'h0041_2283, 32'h8000_0018);
        @(negedge clk);
        check("lw_memread", a.out_memread, 1);
        check("lw_wbsel", a.out_wbsel, 3);
        check("lw_memsize", a.out_memsize, 2);
        check("lw_imm", a.out_imm, 4);
        check("lw_rs1", a.out_rs1, 2);

        // flush together with a new in_valid drops the instruction
        drive(1'b1, 32'h0050_0093, 32'h8000_001C);
        set_flush(1'b1);
        @(negedge clk);
        check("flush_valid", a.out_valid, 0);
        check("flush_imm_kept", a.out_imm, 4);
        check("flush_perf", perf_a, 7);
        set_flush(1'b0);
        drive(1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("flush_dropped", a.out_valid, 0);

        // flush kills a bundle held under backpressure
        set_rdy(1'b0);
        drive(1'b1, 32'h0050_0093, 32'h8000_0020);
        @(negedge clk);
        check("hold_valid", a.out_valid, 1);
        drive(1'b0, 32'h0, 32'h0);
        set_flush(1'b1);
        @(negedge clk);
        check("flush_held", a.out_valid, 0);
        check("flush_held_perf", perf_a, 7);
        set_flush(1'b0);
        set_rdy(1'b1);

        // illegal encodings and RV32E index range
        drive(1'b1, 32'hFFFF_FFFF, 32'h8000_0024);
        @(negedge clk);
        check("ill_ff_flag", a.out_illegal, 1);
        check("ill_ff_rw", a.out_regwrite, 0);
        drive(1'b1, 32'h0020_8833, 32'h8000_0028);
        @(negedge clk);
        check("x16_e_ill", b.out_illegal, 1);
        check("x16_e_rw", b.out_regwrite, 0);
        check("x16_i_ill", a.out_illegal, 0);
        check("x16_i_rw", a.out_regwrite, 1);
        check("x16_i_rd", a.out_rd, 16);
        drive(1'b1, 32'h0000_0013, 32'h8000_002C);
        @(negedge clk);
        check("nop_rw", a.out_regwrite, 0);
        check("nop_ill", a.out_illegal, 0);
        check("nop_valid", a.out_valid, 1);

        // async reset while a bundle is valid
        drive(1'b1, 32'h0050_0093, 32'h8000_0030);
        @(negedge clk);
        check("pre_rst_valid", a.out_valid, 1);
        check("pre_rst_perf", perf_a, 10);
        drive(1'b0, 32'h0, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", a.out_valid, 0);
        check("arst_imm", a.out_imm, 0);
        check("arst_perf", perf_a, 0);
        check("arst_perf_e", perf_b, 0);
        @(negedge clk);
        rst = 1'b0;

        // 17 handshakes: 4-bit counter saturates, 32-bit keeps counting
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 32'h0050_0093, 32'h8000_0100 + 32'(i * 4));
            @(negedge clk);
        end
        drive(1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("cnt_sat", perf_b, 15);
        check("cnt_wide", perf_a, 17);
        check("cnt_idle_valid", a.out_valid, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h0050_0093, 32'h8000_0200);
            @(negedge clk);
        end
        drive(1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("cnt_held", perf_b, 15);
        check("cnt_wide2", perf_a, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ysyx_23060278_idu_stage.md
Name: ysyx_23060278_idu_stage

Overview:
Pipelined successor to the single-cycle decoder. It sits between IFU and EXU as one registered pipeline stage with valid/ready handshakes on both sides. It decodes the full RV32I/RV32E base integer set plus ebreak into a registered control bundle. It also provides immediate generation, illegal-instruction detection, flush, and a saturating decoded-instruction counter.

Parameters:
XLEN, 32, datapath width for pc and imm
REG_AW, 5, register index width (5 = RV32I, 4 = RV32E)
CNT_W, 32, width of the perf counter

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  IFU presents instruction
in_ready  out  1  stage can accept
in_inst  in  32  instruction word
in_pc  in  XLEN  pc of in_inst
flush  in  1  kill held/incoming instruction
out_valid  out  1  decoded bundle valid
out_ready  in  1  EXU accepts bundle
out_pc  out  XLEN  registered pc
out_imm  out  XLEN  sign-extended immediate
out_rs1, out_rs2, out_rd  out  REG_AW each  register indices
out_aluop  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND
out_alusrc_a  out  1  0 rs1, 1 pc
out_alusrc_b  out  1  0 rs2, 1 imm
out_regwrite  out  1  writeback enable
out_wbsel  out  2  00 alu, 01 pc+4, 10 imm, 11 mem
out_memread, out_memwrite  out  1 each  load/store
out_memsize  out  3  funct3 of load/store
out_branch  out  1  conditional branch
out_brfunc  out  3  branch funct3
out_jal, out_jalr, out_ebreak, out_illegal  out  1 each  flags
perf_decoded  out  CNT_W  count of bundles handed to EXU

Behaviour:
- Reset (async, rst=1): out_valid=0. Every out_* field is 0. perf_decoded=0. in_ready follows its combinational equation.
- in_ready = !out_valid | out_ready (combinational; single-entry register).
- Accept = in_valid & in_ready & !flush. On accept, the decode of in_inst/in_pc is registered at the next edge and out_valid=1. Latency is 1 cycle.
- Hold: while out_valid & !out_ready, all out_* fields stay stable.
- Drain: out_valid & out_ready & !accept → out_valid=0 next edge. Drain and accept in the same cycle → the new bundle replaces the old one; no bubble.
- flush=1 → out_valid=0 next edge and no accept that cycle. Flush has priority over in_valid and over a held bundle.
- Immediates:
  - I-type: load, ALU-imm, jalr.
  - S-type: store.
  - B-type: branch.
  - J-type: jal.
  - U-type: imm[31:12] = inst[31:12], low 12 bits zero.
  - All formats are sign-extended from inst[31] to XLEN.
- Per opcode:
  - lui: wbsel=10.
  - auipc: a=pc, b=imm, ADD, wbsel=00.
  - jal: a=pc, b=imm, ADD, wbsel=01, jal=1.
  - jalr: a=rs1, b=imm, ADD, wbsel=01, jalr=1.
  - branch: a=rs1, b=rs2, branch=1, brfunc=f3, no regwrite.
  - load: a=rs1, b=imm, ADD, memread, wbsel=11.
  - store: a=rs1, b=imm, ADD, memwrite, no regwrite.
  - OP-IMM / OP: aluop from f3/f7. SUB only for OP with f7=0100000 and f3=000. SRA/SRAI when f7=0100000 and f3=101.
  - ebreak (exactly 0x00100073): ebreak=1, no regwrite.
- Default aluop is ADD for all non-ALU opcodes.
- regwrite = writing class & rd != 0 & !illegal.
- Illegal cases:
  - unknown opcode;
  - OP with f7 other than 0000000/0100000, or f7=0100000 with f3 not in {000,101};
  - SLLI/SRLI/SRAI with bad f7;
  - load f3 in {011,110,111};
  - store f3 > 010;
  - branch f3 in {010,011};
  - jalr f3 != 0;
  - SYSTEM other than ebreak;
  - when REG_AW=4, any used rs1/rs2/rd index with bit4 set.
- On illegal: out_illegal=1. regwrite, memread, memwrite, branch, jal, jalr and ebreak are forced to 0. pc and inst-derived fields are still registered.
- Index truncation: out_rs1/rs2/rd = inst fields [REG_AW-1:0].
- perf_decoded increments on out_valid & out_ready and saturates at all-ones (no wrap). Flush does not change it.

Test Plan:
- Reset mid-stream: rst=1 asynchronously while out_valid=1 → out_valid=0 and out_imm=0 immediately; perf_decoded=0.
- addi x1,x0,5 (0x00500093), pc=0x80000000, out_ready=1 → next cycle out_valid=1, imm=5, rd=1, aluop=ADD, alusrc_b=1, regwrite=1, wbsel=00. Then sub x3,x1,x2 (0x402081B3) back-to-back → aluop=SUB, rs1=1, rs2=2, no bubble.
- Backpressure: lui x5,0x12345 (0x123452B7) with out_ready=0 for 3 cycles → in_ready=0, imm=0x12345000 and wbsel=10 held stable. Then sw x2,8(x1) (0x0020A423) accepted on the drain cycle → memwrite=1, memsize=010, imm=8, regwrite=0.
- beq x0,x0,-4 (0xFE000EE3) → branch=1, brfunc=000, imm=0xFFFFFFFC. Assert flush in the same cycle as a new in_valid → out_valid=0 next cycle and the instruction is dropped.
- Illegal: 0xFFFFFFFF, and with REG_AW=4 add x16,x1,x2 (0x00208833) → out_illegal=1, regwrite=0. addi x0,x0,0 (0x00000013) → regwrite=0, illegal=0.
- Counter: CNT_W=4, 17 accepted handshakes → perf_decoded=15, held at 15.
